// File: rtl/prf_free_list.sv
// Physical-register free list: a DEPTH-entry ring of free PRF IDs with head (rename pop),
// commit (retired allocation point) and tail (retire reclaim) pointers, plus mispredict rewind.
module prf_free_list #(
   parameter int NUM_PRF = 64,
   parameter int NUM_GPR = 32,
   parameter int DEPTH   = NUM_PRF - NUM_GPR
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alloc_req_ra0,
   output logic                       alloc_ready_ra0,
   output logic [$clog2(NUM_PRF)-1:0] alloc_prf_id_ra0,
   input  logic                       reclaim_prf_rb1,
   input  logic [$clog2(NUM_PRF)-1:0] reclaim_prf_id_rb1,
   input  logic                       br_mispred_rb1,
   output logic [$clog2(DEPTH):0]     free_count
);
   localparam int ID_W  = $clog2(NUM_PRF);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] head_reg, commit_reg, tail_reg;
   logic [PTR_W-1:0] head_next, commit_next, tail_next;
   logic [ID_W-1:0]  entry_reg [DEPTH];
   logic             pop;

   assign alloc_ready_ra0  = (tail_reg != head_reg);
   assign alloc_prf_id_ra0 = entry_reg[head_reg[IDX_W-1:0]];
   assign free_count       = tail_reg - head_reg;
   assign pop              = alloc_req_ra0 && alloc_ready_ra0 && !br_mispred_rb1;

   always_comb begin
      head_next   = head_reg;
      commit_next = commit_reg;
      tail_next   = tail_reg;
      if (reclaim_prf_rb1) begin
         tail_next   = tail_reg + PTR_W'(1);
         commit_next = commit_reg + PTR_W'(1);
      end
      // Rewind lands on the post-reclaim commit point, so a same-cycle retire is honoured.
      if (br_mispred_rb1)
         head_next = commit_next;
      else if (pop)
         head_next = head_reg + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_reg   <= '0;
         commit_reg <= '0;
         tail_reg   <= PTR_W'(DEPTH);
      end else begin
         head_reg   <= head_next;
         commit_reg <= commit_next;
         tail_reg   <= tail_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            entry_reg[i] <= ID_W'(NUM_GPR + i);
      end else if (reclaim_prf_rb1) begin
         entry_reg[tail_reg[IDX_W-1:0]] <= reclaim_prf_id_rb1;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      reclaim_prf_rb1 |-> free_count != PTR_W'(DEPTH));
   a_commit_behind_head: assert property (@(posedge clk) disable iff (!reset)
      reclaim_prf_rb1 |-> head_reg != commit_reg);
   a_id_in_range: assert property (@(posedge clk) disable iff (!reset)
      reclaim_prf_rb1 |-> int'(reclaim_prf_id_rb1) < NUM_PRF);
   a_pointer_order: assert property (@(posedge clk) disable iff (!reset)
      (head_reg - commit_reg) <= (tail_reg - commit_reg));
endmodule

// File: tb/tb_prf_free_list.sv
// Scoreboard bench for prf_free_list: the driver queues expected state and popped IDs,
// a negedge monitor compares them against what the DUT presents.
module tb_prf_free_list;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       alloc_req_ra0 = 1'b0;
   logic       alloc_ready_ra0;
   logic [5:0] alloc_prf_id_ra0;
   logic       reclaim_prf_rb1 = 1'b0;
   logic [5:0] reclaim_prf_id_rb1 = '0;
   logic       br_mispred_rb1 = 1'b0;
   logic [5:0] free_count;

   prf_free_list #(.NUM_PRF(64), .NUM_GPR(32)) dut (
      .clk(clk),
      .reset(reset),
      .alloc_req_ra0(alloc_req_ra0),
      .alloc_ready_ra0(alloc_ready_ra0),
      .alloc_prf_id_ra0(alloc_prf_id_ra0),
      .reclaim_prf_rb1(reclaim_prf_rb1),
      .reclaim_prf_id_rb1(reclaim_prf_id_rb1),
      .br_mispred_rb1(br_mispred_rb1),
      .free_count(free_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    c;
      string name;
      bit    rdy;
      int    cnt;
      bit    chk_id;
      int    id;
   } st_t;

   st_t sq[$];
   int  iq[$];
   int  total = 0;
   int  bad = 0;
   bit  uniq_en = 1'b0;

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit req, input bit rec, input int rid, input bit mis);
      alloc_req_ra0      = req;
      reclaim_prf_rb1    = rec;
      reclaim_prf_id_rb1 = 6'(rid);
      br_mispred_rb1     = mis;
   endtask

   task automatic exp_st(input string n, input bit r, input int c, input bit ci = 0, input int id = 0);
      st_t s;
      s.c = cyc; s.name = n; s.rdy = r; s.cnt = c; s.chk_id = ci; s.id = id;
      sq.push_back(s);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   // Monitor: compares queued expectations and every accepted allocation.
   initial begin
      bit   dut_live [64];
      bit   uniq_prev;
      st_t  s;
      int   e;
      uniq_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            while (sq.size() > 0 && sq[0].c <= cyc) begin
               s = sq.pop_front();
               chk({s.name, "_ready"}, int'(alloc_ready_ra0), int'(s.rdy));
               chk({s.name, "_count"}, int'(free_count), s.cnt);
               if (s.chk_id) chk({s.name, "_id"}, int'(alloc_prf_id_ra0), s.id);
            end
            if (uniq_en && !uniq_prev)
               for (int i = 0; i < 64; i++) dut_live[i] = (i < 32);
            uniq_prev = uniq_en;
            if (alloc_req_ra0 && alloc_ready_ra0 && !br_mispred_rb1) begin
               $display("cycle %0d alloc id=%0d free_count=%0d", cyc, alloc_prf_id_ra0, free_count);
               if (iq.size() == 0) begin
                  chk("unexpected_alloc", int'(alloc_prf_id_ra0), -1);
               end else begin
                  e = iq.pop_front();
                  chk("alloc_id", int'(alloc_prf_id_ra0), e);
               end
               if (uniq_en) begin
                  chk("dup_live_id", int'(dut_live[alloc_prf_id_ra0]), 0);
                  dut_live[alloc_prf_id_ra0] = 1'b1;
               end
            end
            if (uniq_en && reclaim_prf_rb1) dut_live[reclaim_prf_id_rb1] = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int tail_ids[4];
      int free_q[$];
      int live_q[$];
      int spec, vis, k, rid, id;
      bit req, rec;
      tail_ids = '{1, 2, 3, 7};

      // Reset values, then drain all 32 free IDs in order.
      do_reset();
      exp_st("t1_reset", 1, 32, 1, 32);
      for (int i = 0; i < 32; i++) begin
         drive(1, 0, 0, 0); exp_st("t1_alloc", 1, 32 - i, 1, 32 + i); iq.push_back(32 + i); step();
      end
      drive(1, 0, 0, 0); exp_st("t1_empty", 0, 0); step();

      // Reclaim into an empty list: no bypass, visible next cycle.
      drive(1, 1, 5, 0); exp_st("t2_empty_reclaim", 0, 0); step();
      drive(1, 0, 0, 0); exp_st("t2_ready", 1, 1, 1, 5); iq.push_back(5); step();
      drive(0, 0, 0, 0); exp_st("t2_drained", 0, 0); step();

      // Ten allocs, three retires, then mispredict rewinds head to commit.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 0, 0); exp_st("t3_alloc", 1, 32 - i, 1, 32 + i); iq.push_back(32 + i); step();
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, i + 1, 0); exp_st("t3_reclaim", 1, 22 + i); step();
      end
      drive(0, 0, 0, 1); exp_st("t3_pre_mispred", 1, 25); step();
      drive(1, 0, 0, 0); exp_st("t3_rewound", 1, 32, 1, 35); iq.push_back(35); step();

      // Mispredict plus reclaim with alloc_req: alloc dropped, head = commit+1, 7 appended.
      drive(1, 1, 7, 1); exp_st("t4_pre", 1, 31, 1, 36); step();
      for (int i = 0; i < 32; i++) begin
         id = (i < 28) ? 36 + i : tail_ids[i - 28];
         drive(1, 0, 0, 0); exp_st("t4_alloc", 1, 32 - i, 1, id); iq.push_back(id); step();
      end
      drive(0, 0, 0, 0); exp_st("t4_empty", 0, 0); step();

      // Random alloc/reclaim traffic against a free-queue model.
      do_reset();
      free_q.delete(); live_q.delete();
      for (int i = 0; i < 32; i++) begin free_q.push_back(32 + i); live_q.push_back(i); end
      spec = 0;
      uniq_en = 1'b1;
      for (int n = 0; n < 200; n++) begin
         vis = free_q.size();
         req = ($urandom_range(0, 3) != 0);
         rec = 1'b0;
         rid = 0;
         if ($urandom_range(0, 3) != 0 && spec > 0 && vis < 32) begin
            k = $urandom_range(0, live_q.size() - 1);
            rid = live_q[k];
            live_q.delete(k);
            rec = 1'b1;
            spec--;
         end
         drive(req, rec, rid, 0);
         if (vis > 0) exp_st("t5_rand", 1, vis, 1, free_q[0]);
         else exp_st("t5_rand", 0, 0);
         if (req && vis > 0) begin
            id = free_q.pop_front();
            iq.push_back(id);
            live_q.push_back(id);
            spec++;
         end
         if (rec) free_q.push_back(rid);
         step();
      end
      drive(0, 0, 0, 0); step();
      uniq_en = 1'b0;

      // Asynchronous reset mid-stream with seven IDs free.
      do_reset();
      for (int i = 0; i < 25; i++) begin
         drive(1, 0, 0, 0); exp_st("t6_alloc", 1, 32 - i, 1, 32 + i); iq.push_back(32 + i); step();
      end
      drive(0, 0, 0, 0); exp_st("t6_count7", 1, 7, 1, 57); step();
      #1 reset = 1'b0;
      #1;
      chk("t6_async_ready", int'(alloc_ready_ra0), 1);
      chk("t6_async_id", int'(alloc_prf_id_ra0), 32);
      chk("t6_async_count", int'(free_count), 32);
      reset = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0); exp_st("t6_restart", 1, 32 - i, 1, 32 + i); iq.push_back(32 + i); step();
      end
      drive(0, 0, 0, 0); step(); step();

      chk("pending_alloc_ids", iq.size(), 0);
      chk("pending_state_checks", sq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
